// File: rtl/seq_logic_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_logic_unit_if                                                          |
// | Request/response bundle for seq_logic_unit (valid/ready on both sides).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface seq_logic_unit_if #(
   parameter int WIDTH = 8,
   parameter int SW    = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [SW-1:0]    shamt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             err;

   modport master (
      output in_valid, op, a, b, shamt, out_ready,
      input  in_ready, out_valid, result, zero, err
   );

   modport slave (
      input  in_valid, op, a, b, shamt, out_ready,
      output in_ready, out_valid, result, zero, err
   );
endinterface
`default_nettype wire

// File: rtl/seq_logic_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_logic_unit                                                             |
// | Logic/bit-serial shift unit; IDLE -> (SHIFT) -> HOLD -> IDLE handshake.    |
// | Optional: define SEQ_LOGIC_UNIT_ROTATE_EN to make op 111 a serial rotate.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seq_logic_unit #(
   parameter int WIDTH = 8,
   parameter int SW    = 3
) (
   input  wire logic          clk,
   input  wire logic          rst,
   seq_logic_unit_if.slave    bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam logic [2:0]  c_op_and  = 3'b000;
   localparam logic [2:0]  c_op_or   = 3'b001;
   localparam logic [2:0]  c_op_xor  = 3'b010;
   localparam logic [2:0]  c_op_not  = 3'b011;
   localparam logic [2:0]  c_op_any  = 3'b100;
   localparam logic [2:0]  c_op_shl  = 3'b101;
   localparam logic [2:0]  c_op_shr  = 3'b110;
   localparam logic [2:0]  c_op_rot  = 3'b111;

   localparam logic [1:0]  c_dir_left  = 2'd0;
   localparam logic [1:0]  c_dir_right = 2'd1;
   localparam logic [1:0]  c_dir_rotl  = 2'd2;

   localparam int unsigned c_width    = WIDTH;
   localparam logic [SW-1:0] c_cnt_one = SW'(1);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] r_result;
   logic             r_err;
   logic [SW-1:0]    r_cnt;
   logic [1:0]       r_dir;

   logic             w_accept;
   logic             w_serial;
   logic             w_op_err;
   logic [1:0]       w_dir;
   logic [SW-1:0]    w_cnt_load;
   logic [WIDTH-1:0] w_logic_res;
   logic [WIDTH-1:0] w_step;

   assign w_accept      = bus.in_valid && (r_state == ST_IDLE);
   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.out_valid = (r_state == ST_HOLD);
   assign bus.result    = r_result;
   assign bus.err       = r_err;
   assign bus.zero      = (r_result == '0);

   // Out-of-range amounts only exist for non-power-of-two widths, where WIDTH fits in SW bits.
   always_comb begin
      w_cnt_load = bus.shamt;
      if (32'(bus.shamt) >= c_width) begin
         w_cnt_load = SW'(c_width);
      end
   end

   always_comb begin
      w_serial = 1'b0;
      w_dir    = c_dir_left;
      w_op_err = 1'b0;
      case (bus.op)
         c_op_shl: w_serial = 1'b1;
         c_op_shr: begin
            w_serial = 1'b1;
            w_dir    = c_dir_right;
         end
         c_op_rot: begin
`ifdef SEQ_LOGIC_UNIT_ROTATE_EN
            w_serial = 1'b1;
            w_dir    = c_dir_rotl;
`else
            w_op_err = 1'b1;
`endif
         end
         default: w_serial = 1'b0;
      endcase
   end

   always_comb begin
      w_logic_res = '0;
      case (bus.op)
         c_op_and: w_logic_res = bus.a & bus.b;
         c_op_or:  w_logic_res = bus.a | bus.b;
         c_op_xor: w_logic_res = bus.a ^ bus.b;
         c_op_not: w_logic_res = ~bus.a;
         c_op_any: w_logic_res = {{(WIDTH-1){1'b0}}, |bus.a};
         default:  w_logic_res = '0;
      endcase
   end

   always_comb begin
      w_step = {r_work[WIDTH-2:0], 1'b0};
      case (r_dir)
         c_dir_right: w_step = {1'b0, r_work[WIDTH-1:1]};
`ifdef SEQ_LOGIC_UNIT_ROTATE_EN
         c_dir_rotl:  w_step = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
`endif
         default:     w_step = {r_work[WIDTH-2:0], 1'b0};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_serial && (w_cnt_load != '0)) begin
                  w_next = ST_SHIFT;
               end else begin
                  w_next = ST_HOLD;
               end
            end
         end
         ST_SHIFT: begin
            if (r_cnt <= c_cnt_one) begin
               w_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // The final shift step writes straight into the result so HOLD starts with it valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_work   <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
         r_dir    <= c_dir_left;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_err <= w_op_err;
                  r_dir <= w_dir;
                  if (w_serial) begin
                     r_work <= bus.a;
                     r_cnt  <= w_cnt_load;
                     if (w_cnt_load == '0) begin
                        r_result <= bus.a;
                     end
                  end else begin
                     r_result <= w_logic_res;
                  end
               end
            end
            ST_SHIFT: begin
               r_work <= w_step;
               r_cnt  <= r_cnt - c_cnt_one;
               if (r_cnt <= c_cnt_one) begin
                  r_result <= w_step;
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_logic_unit.sv
`default_nettype none
// Testbench for seq_logic_unit: directed cases plus randomized traffic,
// scoreboard queue filled by the driver and drained by an output monitor.
module tb_seq_logic_unit;
   localparam int W = 8;
   localparam int S = 3;

   typedef struct {
      logic [W-1:0] res;
      logic         err;
      int           lat;
      int           acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_logic_unit_if #(.WIDTH(W),  .SW(S)) bus();
   seq_logic_unit_if #(.WIDTH(12), .SW(4)) bus12();

   seq_logic_unit #(.WIDTH(W),  .SW(S)) dut   (.clk(clk), .rst(rst), .bus(bus));
   seq_logic_unit #(.WIDTH(12), .SW(4)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   mon_en = 1'b0;
   bit   holding = 1'b0;
   int   rdy_mode = 2;
   exp_t cur;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Reference: plain arithmetic on the clamped amount; serial ops take amount+1 cycles.
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [S-1:0] sh);
      exp_t e;
      int n;
      logic [2*W-1:0] d;
      n = (int'(sh) >= W) ? W : int'(sh);
      e.err = 1'b0;
      e.lat = 1;
      e.acc = 0;
      e.res = '0;
      case (op)
         3'd0: e.res = a & b;
         3'd1: e.res = a | b;
         3'd2: e.res = a ^ b;
         3'd3: e.res = ~a;
         3'd4: e.res = (a != 0) ? W'(1) : W'(0);
         3'd5: begin e.res = (n >= W) ? W'(0) : W'(a << n); e.lat = n + 1; end
         3'd6: begin e.res = (n >= W) ? W'(0) : W'(a >> n); e.lat = n + 1; end
         default: begin
`ifdef SEQ_LOGIC_UNIT_ROTATE_EN
            d = {a, a} << (n % W);
            e.res = d[2*W-1:W];
            e.lat = n + 1;
`else
            d = '0;
            e.res = d[W-1:0];
            e.err = 1'b1;
`endif
         end
      endcase
      return e;
   endfunction

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [S-1:0] sh);
      exp_t e;
      bit   done = 1'b0;
      @(posedge clk); #1;
      bus.op = op; bus.a = a; bus.b = b; bus.shamt = sh; bus.in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            e = model(op, a, b, sh);
            e.acc = cyc;
            q.push_back(e);
            done = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL accept_timeout op=%0d actual=in_ready0 expected=in_ready1", op);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a = $urandom; bus.b = $urandom; bus.op = 3'($urandom); bus.shamt = S'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || holding) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         checks++; errors++;
         $display("FAIL drain_timeout actual=%0d_pending expected=0", q.size());
      end
   endtask

   task automatic run12(input string nm, input logic [2:0] op, input logic [11:0] a,
                        input logic [3:0] sh, input logic [11:0] er);
      bit got = 1'b0;
      @(posedge clk); #1;
      bus12.op = op; bus12.a = a; bus12.b = '0; bus12.shamt = sh; bus12.in_valid = 1'b1;
      @(posedge clk); #1;
      bus12.in_valid = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus12.out_valid) begin
            got = 1'b1;
            chk(nm, 64'(bus12.result), 64'(er));
            chk({nm, "_zero"}, 64'(bus12.zero), 64'(er == 12'h000));
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual=no_out_valid expected=out_valid", nm);
      end
      @(posedge clk); #1;
   endtask

   always begin
      @(posedge clk); #1;
      case (rdy_mode)
         1:       bus.out_ready = 1'b0;
         2:       bus.out_ready = 1'b1;
         default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Output monitor: first HOLD cycle pops the scoreboard, later HOLD cycles check stability.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && !rst && bus.out_valid) begin
            chk("in_ready_in_hold", 64'(bus.in_ready), 64'(0));
            if (!holding) begin
               if (q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_output actual=out_valid1 expected=out_valid0");
                  cur.res = bus.result; cur.err = bus.err;
               end else begin
                  cur = q.pop_front();
                  chk("result", 64'(bus.result), 64'(cur.res));
                  chk("err", 64'(bus.err), 64'(cur.err));
                  chk("zero", 64'(bus.zero), 64'(cur.res == '0));
                  chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
               end
               holding = 1'b1;
            end else begin
               chk("hold_result", 64'(bus.result), 64'(cur.res));
               chk("hold_err", 64'(bus.err), 64'(cur.err));
            end
            if (bus.out_ready) holding = 1'b0;
         end
      end
   end

   initial begin
      bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.shamt = '0;
      bus12.in_valid = 1'b0; bus12.op = '0; bus12.a = '0; bus12.b = '0; bus12.shamt = '0;
      bus12.out_ready = 1'b1;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_result", 64'(bus.result), 64'(0));
      chk("rst_zero", 64'(bus.zero), 64'(1));
      chk("rst_err", 64'(bus.err), 64'(0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", 64'(bus.in_ready), 64'(1));
      mon_en = 1'b1;

      rdy_mode = 2;
      issue(3'b000, 8'hF0, 8'h3C, 3'd0);
      drain();

      issue(3'b101, 8'h81, 8'h00, 3'd3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("in_ready_in_shift", 64'(bus.in_ready), 64'(0));
         chk("out_valid_in_shift", 64'(bus.out_valid), 64'(0));
      end
      drain();

      rdy_mode = 1;
      issue(3'b011, 8'hFF, 8'h00, 3'd0);
      repeat (6) @(negedge clk);
      rdy_mode = 2;
      drain();

      issue(3'b111, 8'h81, 8'h00, 3'd1);
      drain();

      // Reset in the second SHIFT cycle discards the operation.
      mon_en = 1'b0;
      issue(3'b110, 8'h80, 8'h00, 3'd2);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midshift_rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("midshift_rst_result", 64'(bus.result), 64'(0));
      chk("midshift_rst_zero", 64'(bus.zero), 64'(1));
      q.delete();
      holding = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_midshift_rst", 64'(bus.in_ready), 64'(1));
      mon_en = 1'b1;
      issue(3'b000, 8'hA5, 8'h0F, 3'd0);
      drain();

      rdy_mode = 0;
      for (int i = 0; i < 150; i++) begin
         issue(3'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      rdy_mode = 2;
      drain();

      run12("w12_any_zero", 3'b100, 12'h000, 4'd0, 12'h000);
      run12("w12_shr_clamp", 3'b110, 12'hFFF, 4'd15, 12'h000);
      run12("w12_shl_3", 3'b101, 12'h0F1, 4'd3, 12'h788);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
